// File: rtl/program_counter.sv
// Program counter for the multi-cycle datapath: each clock it either steps by INC,
// takes an absolute jump, or takes a flag-qualified branch to (word target * 2) + INC.
module program_counter #(
    parameter int                WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                INC         = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             input_PCWrite,
    input  logic [WIDTH-1:0] input_newPC,
    input  logic             input_zero,
    input  logic             input_negative,
    input  logic [1:0]       input_branchType,
    input  logic             input_PC_isbranch,
    input  logic             input_PC_set,
    output logic [WIDTH-1:0] output_PC
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } branch_type_e;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] seq_pc;
    logic             branch_taken;
    branch_type_e     branch_type;

    // Word-to-byte conversion; the top bit of newPC falls off the end.
    assign target      = input_newPC << 1;
    assign seq_pc      = pc_q + INC_W;
    assign branch_type = branch_type_e'(input_branchType);

    always_comb begin
        branch_taken = 1'b0;
        case (branch_type)
            BR_EQ:   branch_taken = input_zero;
            BR_NE:   branch_taken = ~input_zero;
            BR_LT:   branch_taken = input_negative;
            BR_GE:   branch_taken = ~input_negative;
            default: branch_taken = 1'b0;
        endcase
    end

    // Jump outranks branch; everything else falls through to the sequential step.
    always_comb begin
        pc_d = seq_pc;
        if (input_PCWrite) begin
            if (input_PC_set) begin
                pc_d = target;
            end else if (input_PC_isbranch && branch_taken) begin
                pc_d = target + INC_W;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign output_PC = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter: each vector drives one clock edge and
// compares output_PC against a hand-computed value.
module tb_program_counter;

    logic        clk;
    logic        reset_n;
    logic        pc_write;
    logic [15:0] new_pc;
    logic        zero;
    logic        negative;
    logic [1:0]  branch_type;
    logic        is_branch;
    logic        pc_set;
    logic [15:0] pc_out;

    int checks_total;
    int checks_passed;

    program_counter #(
        .WIDTH(16),
        .RESET_VALUE(16'h0000),
        .INC(2)
    ) dut (
        .CLK              (clk),
        .RESET_N          (reset_n),
        .input_PCWrite    (pc_write),
        .input_newPC      (new_pc),
        .input_zero       (zero),
        .input_negative   (negative),
        .input_branchType (branch_type),
        .input_PC_isbranch(is_branch),
        .input_PC_set     (pc_set),
        .output_PC        (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the output is sampled just after the rising edge.
    task automatic applyStimulus(input logic rst_n_i, input logic write_i, input logic set_i,
                                 input logic br_i, input logic [1:0] type_i, input logic zero_i,
                                 input logic neg_i, input logic [15:0] newpc_i);
        @(negedge clk);
        reset_n     = rst_n_i;
        pc_write    = write_i;
        pc_set      = set_i;
        is_branch   = br_i;
        branch_type = type_i;
        zero        = zero_i;
        negative    = neg_i;
        new_pc      = newpc_i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: output_PC=%h expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_n     = 1'b0;
        pc_write    = 1'b0;
        pc_set      = 1'b0;
        is_branch   = 1'b0;
        branch_type = 2'b00;
        zero        = 1'b0;
        negative    = 1'b0;
        new_pc      = 16'h0000;

        //            rst  wr   set  br   type   z    n    newPC
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1234);
        checkOutput("reset", pc_out, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000);
        checkOutput("seq1", pc_out, 16'h0002);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000);
        checkOutput("seq2", pc_out, 16'h0004);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234);
        checkOutput("jump", pc_out, 16'h2468);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1234);
        checkOutput("jump_over_branch", pc_out, 16'h2468);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000);
        checkOutput("beq_taken", pc_out, 16'h0002);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234);
        checkOutput("jump_back", pc_out, 16'h2468);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000);
        checkOutput("beq_not_taken", pc_out, 16'h246A);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 16'h0010);
        checkOutput("bne_taken", pc_out, 16'h0022);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 16'h0010);
        checkOutput("bne_not_taken", pc_out, 16'h0024);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 16'h0010);
        checkOutput("blt_taken", pc_out, 16'h0022);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 16'h0010);
        checkOutput("blt_not_taken", pc_out, 16'h0024);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 16'h0010);
        checkOutput("bge_taken", pc_out, 16'h0022);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 16'h0010);
        checkOutput("bge_not_taken", pc_out, 16'h0024);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'h0010);
        checkOutput("write_no_ctrl", pc_out, 16'h0026);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0020);
        checkOutput("jump_40", pc_out, 16'h0040);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0100);
        checkOutput("set_ignored", pc_out, 16'h0042);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0100);
        checkOutput("branch_ignored", pc_out, 16'h0044);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h7FFF);
        checkOutput("jump_top", pc_out, 16'hFFFE);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000);
        checkOutput("seq_wrap", pc_out, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'hFFFF);
        checkOutput("jump_msb_dropped", pc_out, 16'hFFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h7FFF);
        checkOutput("branch_wrap", pc_out, 16'h0000);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234);
        checkOutput("jump_pre_reset", pc_out, 16'h2468);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0010);
        checkOutput("reset_over_branch", pc_out, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000);
        checkOutput("seq_after_reset", pc_out, 16'h0002);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter for the multi-cycle processor datapath; holds the byte address of the current instruction.
- Every clock it either advances by 2, loads an absolute jump target, or takes a conditional branch based on the ALU zero/negative flags.
- Sits between control unit (PCWrite, PC_isbranch, PC_set, branchType), ALU flags, and the instruction memory address input.

Parameters:
- WIDTH, 16, PC and newPC width in bits.
- RESET_VALUE, 16'h0000, PC value loaded on reset.
- INC, 2, increment in bytes per sequential step (16-bit instructions).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET_N  input  1  synchronous active-low reset.
- input_PCWrite  input  1  1 = control-flow update cycle (jump/branch evaluation); 0 = sequential increment.
- input_newPC  input  WIDTH  target as a word address; byte target = newPC shifted left by 1.
- input_zero  input  1  ALU zero flag.
- input_negative  input  1  ALU negative flag.
- input_branchType  input  2  00 beq, 01 bne, 10 blt, 11 bge.
- input_PC_isbranch  input  1  current instruction is a conditional branch.
- input_PC_set  input  1  current instruction is an unconditional jump/set.
- output_PC  output  WIDTH  registered PC value.

Behaviour:
- All updates on rising CLK; output_PC is the register output directly, with no combinational path from inputs.
- Reset: if RESET_N=0 at a rising edge, PC <= RESET_VALUE (0x0000). Reset has top priority and aborts any update in that cycle.
- Byte target T = {input_newPC[WIDTH-2:0], 1'b0}, i.e. newPC*2 truncated to WIDTH bits.
- Branch condition C by input_branchType:
  - 00 beq: zero=1.
  - 01 bne: zero=0.
  - 10 blt: negative=1.
  - 11 bge: negative=0.
- Next-PC priority when RESET_N=1:
  1. input_PCWrite=0: PC <= PC + INC. input_PC_set and input_PC_isbranch are ignored.
  2. input_PCWrite=1 and input_PC_set=1: PC <= T. Set wins over isbranch if both are asserted.
  3. input_PCWrite=1, input_PC_isbranch=1, C=1 (taken): PC <= T + INC.
  4. input_PCWrite=1, branch not taken, or neither set nor isbranch: PC <= PC + INC.
- Arithmetic is modulo 2^WIDTH. 0xFFFE + 2 wraps to 0x0000, and T + INC wraps the same way. newPC bit 15 is discarded by the shift.
- Latency: one cycle. The new value is visible on output_PC after the edge that samples the inputs.
- Flags and branchType are sampled only at the edge; they are don't-care unless PCWrite=1 and isbranch=1 and set=0.
- No X propagation on reset: after the first reset edge, output_PC is a defined value.

Test Plan:
- Reset: RESET_N=0 for one edge with arbitrary inputs -> output_PC=0x0000. Then RESET_N=1, PCWrite=0, set=0, isbranch=0 for one edge -> 0x0002; a second edge -> 0x0004.
- Jump: from any PC, PCWrite=1, PC_set=1, newPC=0x1234 -> output_PC=0x2468 after one edge. With isbranch=1 also asserted, the result is still 0x2468.
- beq taken: PC=0x2468; PCWrite=1, isbranch=1, set=0, branchType=00, zero=1, newPC=0x0000 -> 0x0002. Same inputs with zero=0 -> 0x246A.
- Branch types: newPC=0x0010, PCWrite=1, isbranch=1:
  - bne with zero=0 -> 0x0022.
  - blt with negative=1 -> 0x0022; blt with negative=0 -> PC+2.
  - bge with negative=0 -> 0x0022.
- PCWrite=0 override: PCWrite=0, set=1, newPC=0x0100, PC=0x0040 -> 0x0042 (set ignored).
- Wrap and mid-operation reset:
  - PC=0xFFFE with PCWrite=0 -> 0x0000.
  - newPC=0xFFFF with set -> 0xFFFE.
  - RESET_N=0 in the same cycle as a taken branch -> 0x0000.
